// File: rtl/or_reduce_pipe.sv
// Masked WIDTH-input OR reduction built as a FANIN-ary tree, optionally registered per level, with sticky mode.
// Latency max(1,D) cycles when PIPE=1, else 1; accepts one sample every cycle and never stalls.
module or_reduce_pipe #(
    parameter int WIDTH  = 16,
    parameter int FANIN  = 2,
    parameter int PIPE   = 1,
    parameter int STICKY = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] M,
    input  logic             V,
    input  logic             CLR,
    output logic             Y,
    output logic             YV
);

    function automatic int calc_depth(input int w, input int f);
        int n;
        int d;
        n = w;
        d = 0;
        while (n > 1) begin
            n = (n + f - 1) / f;
            d = d + 1;
        end
        return d;
    endfunction

    localparam int D  = calc_depth(WIDTH, FANIN);
    localparam int NL = D + 1;
    localparam int L  = (PIPE != 0 && D > 1) ? D : 1;

    // lvl[k] holds the OR outputs of tree level k, zero above that level's width
    logic [WIDTH-1:0] lvl     [NL];
    logic [WIDTH-1:0] stage_d [NL];
    logic [WIDTH-1:0] stage_q [NL];
    logic [L-1:0]     vld_d;
    logic [L-1:0]     vld_q;
    logic             y_d;
    logic             y_q;
    logic             end_or;
    logic             end_vld;
    logic [WIDTH-1:0] src;
    int               idx;

    always_comb begin
        for (int k = 0; k < NL; k++) begin
            lvl[k]     = '0;
            stage_d[k] = '0;
        end
        src    = '0;
        idx    = 0;
        lvl[0] = A & M;
        for (int k = 1; k < NL; k++) begin
            // With PIPE, the final level is left unregistered: it feeds the output flop directly
            src = (PIPE != 0 && k > 1) ? stage_q[k-1] : lvl[k-1];
            for (int j = 0; j < WIDTH; j++) begin
                for (int f = 0; f < FANIN; f++) begin
                    idx = j * FANIN + f;
                    if (idx < WIDTH) begin
                        lvl[k][j] = lvl[k][j] | src[idx];
                    end
                end
            end
            stage_d[k] = lvl[k];
        end
        end_or = lvl[D][0];

        vld_d    = vld_q;
        vld_d[0] = V;
        for (int i = 1; i < L; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        end_vld = vld_d[L-1];

        y_d = y_q;
        if (STICKY != 0) begin
            // A valid set outranks a concurrent clear so an event is never dropped
            if (end_vld && end_or) begin
                y_d = 1'b1;
            end else if (CLR) begin
                y_d = 1'b0;
            end
        end else if (end_vld) begin
            y_d = end_or;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            for (int k = 0; k < NL; k++) begin
                stage_q[k] <= '0;
            end
            vld_q <= '0;
            y_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NL; k++) begin
                stage_q[k] <= stage_d[k];
            end
            vld_q <= vld_d;
            y_q   <= y_d;
        end
    end

    assign Y  = y_q;
    assign YV = vld_q[L-1];

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Bench for or_reduce_pipe: five configurations share clock/reset, each with its own valid and clear.
module tb_or_reduce_pipe;

    localparam int NDUT = 5;

    typedef struct {
        int dut;
        int due;
        bit val;
    } exp_t;

    logic        CLK;
    logic        RN;
    logic [15:0] a_bus;
    logic [15:0] m_bus;
    logic        v_v     [NDUT];
    logic        clr_v   [NDUT];
    logic        y_w     [NDUT];
    logic        yv_w    [NDUT];
    logic        edge_clr[NDUT];
    logic        model_y [NDUT];
    logic        edge_rn;
    int          cyc;
    int          n_chk;
    int          n_fail;
    exp_t        sb[$];

    or_reduce_pipe #(.WIDTH(16), .FANIN(2), .PIPE(1), .STICKY(0)) u_base (
        .CLK(CLK), .RN(RN), .A(a_bus), .M(m_bus), .V(v_v[0]), .CLR(clr_v[0]), .Y(y_w[0]), .YV(yv_w[0]));
    or_reduce_pipe #(.WIDTH(16), .FANIN(2), .PIPE(1), .STICKY(1)) u_sticky (
        .CLK(CLK), .RN(RN), .A(a_bus), .M(m_bus), .V(v_v[1]), .CLR(clr_v[1]), .Y(y_w[1]), .YV(yv_w[1]));
    or_reduce_pipe #(.WIDTH(5), .FANIN(3), .PIPE(1), .STICKY(0)) u_odd (
        .CLK(CLK), .RN(RN), .A(a_bus[4:0]), .M(m_bus[4:0]), .V(v_v[2]), .CLR(clr_v[2]), .Y(y_w[2]), .YV(yv_w[2]));
    or_reduce_pipe #(.WIDTH(5), .FANIN(3), .PIPE(0), .STICKY(0)) u_comb (
        .CLK(CLK), .RN(RN), .A(a_bus[4:0]), .M(m_bus[4:0]), .V(v_v[3]), .CLR(clr_v[3]), .Y(y_w[3]), .YV(yv_w[3]));
    or_reduce_pipe #(.WIDTH(1), .FANIN(2), .PIPE(1), .STICKY(0)) u_one (
        .CLK(CLK), .RN(RN), .A(a_bus[0:0]), .M(m_bus[0:0]), .V(v_v[4]), .CLR(clr_v[4]), .Y(y_w[4]), .YV(yv_w[4]));

    function automatic int lat(input int d);
        case (d)
            0, 1:    return 4;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_sticky(input int d);
        return d == 1;
    endfunction

    function automatic logic [15:0] wmask(input int d);
        case (d)
            0, 1:    return 16'hFFFF;
            2, 3:    return 16'h001F;
            default: return 16'h0001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int d, input logic [15:0] a, input logic [15:0] m, input bit v, input bit clr);
        exp_t e;
        @(posedge CLK);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            v_v[i]   = 1'b0;
            clr_v[i] = 1'b0;
        end
        a_bus    = a;
        m_bus    = m;
        v_v[d]   = v;
        clr_v[d] = clr;
        if (v) begin
            e.dut = d;
            e.due = cyc + lat(d);
            e.val = |(a & m & wmask(d));
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic mon(input int d);
        int idx;
        bit due_now;
        bit val;
        idx     = -1;
        due_now = 1'b0;
        val     = 1'b0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].dut == d) begin
                idx = i;
                break;
            end
        end
        if (idx >= 0 && sb[idx].due == cyc) begin
            due_now = 1'b1;
            val     = sb[idx].val;
            sb.delete(idx);
        end
        if (!edge_rn) begin
            model_y[d] = 1'b0;
        end else if (is_sticky(d)) begin
            if (due_now && val) model_y[d] = 1'b1;
            else if (edge_clr[d]) model_y[d] = 1'b0;
        end else if (due_now) begin
            model_y[d] = val;
        end
        check($sformatf("yv[%0d]", d), 32'(yv_w[d]), 32'(due_now));
        check($sformatf("y[%0d]", d), 32'(y_w[d]), 32'(model_y[d]));
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc     = cyc + 1;
            edge_rn = RN;
            for (int d = 0; d < NDUT; d++) edge_clr[d] = clr_v[d];
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (cyc > 0) begin
                // A reset edge discards every in-flight sample in all instances
                if (!edge_rn) sb.delete();
                for (int d = 0; d < NDUT; d++) mon(d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc     = 0;
        n_chk   = 0;
        n_fail  = 0;
        edge_rn = 1'b0;
        RN      = 1'b0;
        a_bus   = 16'hFFFF;
        m_bus   = 16'hFFFF;
        for (int d = 0; d < NDUT; d++) begin
            v_v[d]      = 1'b1;
            clr_v[d]    = 1'b0;
            edge_clr[d] = 1'b0;
            model_y[d]  = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        RN    = 1'b1;
        a_bus = 16'h0000;
        for (int d = 0; d < NDUT; d++) v_v[d] = 1'b0;

        // Single-sample latency
        step(0, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        idle(6);

        // Back-to-back stream with bit 8 masked, then a bubble
        step(0, 16'h0000, 16'hFEFF, 1'b1, 1'b0);
        step(0, 16'h8000, 16'hFEFF, 1'b1, 1'b0);
        step(0, 16'h0000, 16'hFEFF, 1'b1, 1'b0);
        step(0, 16'h0100, 16'hFEFF, 1'b1, 1'b0);
        step(0, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
        step(0, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        step(0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        step(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle(6);

        // Sticky: set, hold, clear, then clear colliding with a set
        step(1, 16'h0010, 16'hFFFF, 1'b1, 1'b0);
        idle(14);
        check("sticky_hold", 32'(y_w[1]), 32'd1);
        step(1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        idle(2);
        check("sticky_clr", 32'(y_w[1]), 32'd0);
        step(1, 16'h0200, 16'hFFFF, 1'b1, 1'b0);
        idle(2);
        step(1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        idle(4);
        check("sticky_collide", 32'(y_w[1]), 32'd1);
        step(1, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        idle(5);
        step(1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        idle(2);

        // Odd geometry, pipelined and combinational
        for (int d = 2; d <= 3; d++) begin
            step(d, 16'h0010, 16'h001F, 1'b1, 1'b0);
            step(d, 16'h0008, 16'h0017, 1'b1, 1'b0);
            step(d, 16'h0004, 16'h001F, 1'b1, 1'b0);
            step(d, 16'h0000, 16'h001F, 1'b1, 1'b0);
            idle(4);
        end

        // Degenerate width
        step(4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        step(4, 16'h0001, 16'h0000, 1'b1, 1'b0);
        step(4, 16'h0000, 16'h0001, 1'b1, 1'b0);
        step(4, 16'h0001, 16'h0001, 1'b1, 1'b0);
        idle(3);

        // Reset mid-flight
        step(0, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        idle(5);
        check("pre_reset_y", 32'(y_w[0]), 32'd1);
        step(0, 16'h0400, 16'hFFFF, 1'b1, 1'b0);
        idle(1);
        @(posedge CLK);
        #1;
        RN = 1'b0;
        for (int d = 0; d < NDUT; d++) v_v[d] = 1'b0;
        @(posedge CLK);
        #1;
        RN = 1'b1;
        idle(6);
        check("midflight_y", 32'(y_w[0]), 32'd0);

        idle(2);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
